// File: rtl/alu_exec.sv
// Multi-cycle ALU with a valid/ready handshake on both sides. Shifts run one bit per cycle,
// and a 16-bit counter records every result taken by the consumer.

package definitions;
    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        SLL = 3'b010,
        SRL = 3'b011,
        EQU = 3'b100,
        GTR = 3'b101,
        AND = 3'b110,
        XOR = 3'b111
    } ALU_Ops;
endpackage

module alu_exec #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  definitions::ALU_Ops op,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        result,
    output logic                carry,
    output logic                zero,
    output logic [15:0]         ops_done
);
    import definitions::*;

    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_d;
    logic [W-1:0]  result_d;
    logic          carry_d, zero_d;
    logic [SW-1:0] count, count_d;
    logic          left, left_d;
    logic [15:0]   ops_d;
    logic [W:0]    sum;
    logic [SW-1:0] amount;

    assign sum       = {1'b0, a} + {1'b0, b};
    assign amount    = b[SW-1:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // The result register doubles as the shift register while in SHIFT.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state;
        result_d = result;
        carry_d  = carry;
        zero_d   = zero;
        count_d  = count;
        left_d   = left;
        ops_d    = ops_done;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    carry_d = 1'b0;
                    state_d = DONE;
                    case (op)
                        ADD: {carry_d, result_d} = sum;
                        SUB: begin
                            result_d = a - b;
                            carry_d  = (a < b);
                        end
                        SLL, SRL: begin
                            result_d = a;
                            left_d   = (op == SLL);
                            count_d  = amount;
                            if (amount != '0) state_d = SHIFT;
                        end
                        EQU:     result_d = {{(W-1){1'b0}}, a == b};
                        GTR:     result_d = {{(W-1){1'b0}}, a > b};
                        AND:     result_d = a & b;
                        default: result_d = a ^ b;
                    endcase
                    zero_d = (result_d == '0);
                end
            end
            SHIFT: begin
                if (left) {carry_d, result_d} = {result, 1'b0};
                else      {result_d, carry_d} = {1'b0, result};
                zero_d  = (result_d == '0);
                count_d = count - SW'(1);
                if (count == SW'(1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    ops_d   = ops_done + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            count    <= '0;
            left     <= 1'b0;
            ops_done <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_d;
            result   <= result_d;
            carry    <= carry_d;
            zero     <= zero_d;
            count    <= count_d;
            left     <= left_d;
            ops_done <= ops_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec (W=8): arithmetic/logic ops, shift timing, result hold,
// reset abort and ops_done wrap.

module tb_alu_exec;
    import definitions::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    ALU_Ops     op;
    logic [7:0] a, b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic [15:0] ops_done;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ops  = 0;

    alu_exec #(.W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .ops_done (ops_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait for the result, check it, then let it be taken.
    // exp_wait is the number of edges after the accept edge before out_valid is seen:
    // 0 for single-cycle ops, n for an n-bit shift.
    task automatic do_op(input string tag, input ALU_Ops o, input logic [7:0] x, input logic [7:0] y,
                         input int exp_wait, input logic [7:0] er, input logic ec, input logic ez);
        int waited;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        a        = ~x;
        b        = ~y;
        waited   = 0;
        while (!out_valid && waited < 20) begin
            tick;
            waited++;
        end
        check({tag, "_wait"},   waited, exp_wait);
        check({tag, "_result"}, result, er);
        check({tag, "_carry"},  carry,  ec);
        check({tag, "_zero"},   zero,   ez);
        tick;
        exp_ops++;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_ops_done"}, ops_done, 16'(exp_ops));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = ADD;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b1;
        repeat (2) tick;
        check("rst_flags", {in_ready, out_valid, carry, zero}, 4'b1000);
        check("rst_result", result, 8'h00);
        check("rst_ops", ops_done, 16'h0000);
        reset = 1'b0;

        // First request lands on the first edge after reset release.
        do_op("add_f0_20", ADD, 8'hF0, 8'h20, 0, 8'h10, 1'b1, 1'b0);
        do_op("sll_81_3",  SLL, 8'h81, 8'h03, 3, 8'h08, 1'b0, 1'b0);
        do_op("srl_81_0",  SRL, 8'h81, 8'h00, 0, 8'h81, 1'b0, 1'b0);
        do_op("sub_03_05", SUB, 8'h03, 8'h05, 0, 8'hFE, 1'b1, 1'b0);
        do_op("sub_05_03", SUB, 8'h05, 8'h03, 0, 8'h02, 1'b0, 1'b0);
        do_op("equ_05_05", EQU, 8'h05, 8'h05, 0, 8'h01, 1'b0, 1'b0);
        do_op("gtr_05_05", GTR, 8'h05, 8'h05, 0, 8'h00, 1'b0, 1'b1);
        do_op("gtr_06_05", GTR, 8'h06, 8'h05, 0, 8'h01, 1'b0, 1'b0);
        do_op("and_f0_3c", AND, 8'hF0, 8'h3C, 0, 8'h30, 1'b0, 1'b0);
        do_op("xor_ff_ff", XOR, 8'hFF, 8'hFF, 0, 8'h00, 1'b0, 1'b1);
        do_op("add_80_80", ADD, 8'h80, 8'h80, 0, 8'h00, 1'b1, 1'b1);
        do_op("srl_01_1",  SRL, 8'h01, 8'h01, 1, 8'h00, 1'b1, 1'b1);
        do_op("sll_01_f9", SLL, 8'h01, 8'hF9, 1, 8'h02, 1'b0, 1'b0);
        do_op("sll_01_7",  SLL, 8'h01, 8'h07, 7, 8'h80, 1'b0, 1'b0);
        do_op("sll_c0_2",  SLL, 8'hC0, 8'h02, 2, 8'h00, 1'b1, 1'b1);

        // Result must hold in DONE while the consumer stalls and new requests keep arriving.
        op        = XOR;
        a         = 8'h0F;
        b         = 8'hF0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            op = ADD;
            a  = 8'(i * 37 + 1);
            b  = 8'(i * 11 + 3);
            check($sformatf("hold_%0d", i), {in_ready, out_valid, carry, zero, result}, {4'b0100, 8'hFF});
            tick;
        end
        check("hold_ops", ops_done, 16'(exp_ops));
        out_ready = 1'b1;
        tick;
        exp_ops++;
        // in_valid is still high on the take edge; no request may be accepted there.
        check("take_idle", {in_ready, out_valid}, 2'b10);
        check("take_ops", ops_done, 16'(exp_ops));
        check("take_result", result, 8'hFF);
        in_valid = 1'b0;

        // Reset during the third SHIFT cycle of a 7-bit right shift.
        op       = SRL;
        a        = 8'hFF;
        b        = 8'h07;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (2) tick;
        check("mid_shift_busy", {in_ready, out_valid}, 2'b00);
        reset = 1'b1;
        #1;
        check("abort_flags", {in_ready, out_valid, carry, zero}, 4'b1000);
        check("abort_result", result, 8'h00);
        check("abort_ops", ops_done, 16'h0000);
        tick;
        check("abort_hold", {in_ready, out_valid}, 2'b10);
        reset   = 1'b0;
        exp_ops = 0;
        do_op("add_1_1", ADD, 8'h01, 8'h01, 0, 8'h02, 1'b0, 1'b0);

        // Counter wrap: restart from zero and complete 65536 XORs back to back.
        reset = 1'b1;
        tick;
        reset     = 1'b0;
        op        = XOR;
        a         = 8'h5A;
        b         = 8'h0F;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2 * 65535) @(posedge clk);
        #1;
        check("wrap_ffff", ops_done, 16'hFFFF);
        check("wrap_xor_result", result, 8'h55);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("wrap_zero", ops_done, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
